// File: rtl/spi_multi_master_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_multi_master_pkg
//  Purpose  : Shared definitions for the SPI multiplier-peripheral master:
//             FSM state encoding, frame width and a small constant helper.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_multi_master_pkg;

  // Bits per SPI frame, used for both the write and read phases
  localparam int FRAME_BITS = 8;

  // Transaction sequencer states; 3-bit encoding with explicit values
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WRITE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Larger of two integers, for sizing counters that serve several phases
  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_multi_master_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module   : spi_multi_master_sclk_gen
//  Purpose  : SCLK divider. While en is high, SCLK alternates CLK_DIV cycles
//             low and CLK_DIV cycles high, always starting with a low phase.
//             Pulses are combinational and mark the clock edge at which the
//             named event takes place.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_multi_master_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic sclk,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic last_high
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             phase_end;

  // Divider next-state: disabled means held at zero with SCLK low, so the
  // next enable always begins with a full low phase.
  always_comb begin
    phase_end = en && (div_q == DIV_LAST);
    div_d     = '0;
    sclk_d    = 1'b0;
    if (en) begin
      div_d  = phase_end ? '0 : div_q + DIV_W'(1);
      sclk_d = sclk_q ^ phase_end;
    end
  end

  // Divider and SCLK level registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk       = sclk_q;
  assign rise_pulse = phase_end && !sclk_q;
  assign fall_pulse = phase_end && sclk_q;
  // The final CLK of a high phase is the same cycle whose closing edge drops SCLK
  assign last_high  = phase_end && sclk_q;

endmodule
`default_nettype wire

// File: rtl/spi_multi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_multi_master
//  Purpose  : Host-side SPI master for the 4x4 multiplier peripheral. Shifts
//             {b,a} out on MOSI, waits for the compute time, then shifts the
//             8-bit product in on MISO and reports it with a done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_multi_master
  import spi_multi_master_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int WAIT_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic       CS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  // The wait counter also times SETUP and HOLD, so it must reach CLK_DIV-1 too
  localparam int CNT_W = max_int($clog2(WAIT_CYCLES + 1), $clog2(CLK_DIV + 1));
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [7:0]              product_q, product_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic                    cs_q, cs_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    miso_s1_q, miso_s2_q;

  logic                    sclk_en;
  logic                    sclk_lvl;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    sclk_last_high;

  assign sclk_en = (state_q == ST_WRITE) || (state_q == ST_READ);

  spi_multi_master_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .en         (sclk_en),
    .sclk       (sclk_lvl),
    .rise_pulse (sclk_rise),
    .fall_pulse (sclk_fall),
    .last_high  (sclk_last_high)
  );

  // Two-flop synchroniser for the asynchronous MISO line
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
    end else begin
      miso_s1_q <= MISO;
      miso_s2_q <= miso_s2_d(miso_s1_q);
    end
  end

  function automatic logic miso_s2_d(input logic s1);
    return s1;
  endfunction

  // Sequencer next-state and output decode
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    product_d = product_q;
    bit_d     = bit_q;
    wait_d    = wait_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    // Counts SCLK rises modulo the frame size: it wraps back to zero on the
    // final rise, so a zero count during a high phase marks the last bit.
    if (sclk_rise) begin
      bit_d = bit_q + BIT_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start) begin
          tx_d    = {b, a};
          mosi_d  = b[3];
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wait_d = wait_q + CNT_W'(1);
        if (wait_q == DIV_LAST) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (sclk_fall) begin
          if (bit_q == '0) begin
            mosi_d  = 1'b0;
            state_d = ST_WAIT;
          end else begin
            // Rotate rather than shift so every tx bit stays live
            mosi_d = tx_q[FRAME_BITS-2];
            tx_d   = {tx_q[FRAME_BITS-2:0], tx_q[FRAME_BITS-1]};
          end
        end
      end
      ST_WAIT: begin
        wait_d = wait_q + CNT_W'(1);
        if (wait_q == WAIT_LAST) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (sclk_last_high) begin
          rx_d = {rx_q[FRAME_BITS-2:0], miso_s2_q};
          if (bit_q == '0) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        wait_d = wait_q + CNT_W'(1);
        if (wait_q == DIV_LAST) begin
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = rx_q;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Every state change starts the phase counters from zero
    if (state_d != state_q) begin
      bit_d  = '0;
      wait_d = '0;
    end
  end

  // Sequencer state, shift registers, counters and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      product_q <= 8'h00;
      bit_q     <= '0;
      wait_q    <= '0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      product_q <= product_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign CS      = cs_q;
  assign SCLK    = sclk_lvl;
  assign MOSI    = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_multi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_multi_master
//  Purpose  : Self-checking bench for spi_multi_master. Instance 0 uses the
//             default timing, instance 1 uses CLK_DIV=2 / WAIT_CYCLES=1.
//             Each instance talks to a behavioural multiplier peripheral.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_multi_master;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]        start_v;
  logic [1:0][3:0]   a_v;
  logic [1:0][3:0]   b_v;
  logic [1:0]        busy_v, done_v, cs_v, sclk_v, mosi_v;
  logic [1:0][7:0]   prod_v;
  logic [1:0][7:0]   rx_v;
  logic [1:0][31:0]  lrise_v;
  logic [1:0][31:0]  csr_v;
  logic [1:0][31:0]  dcnt_v;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CD = (g == 0) ? 4 : 2;
    localparam int WC = (g == 0) ? 16 : 1;

    logic       miso    = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] ret     = 8'h00;
    logic [2:0] idx;
    int         rises      = 0;
    int         last_rises = 0;
    int         cs_rises   = 0;
    int         dones      = 0;

    spi_multi_master #(
      .CLK_DIV     (CD),
      .WAIT_CYCLES (WC)
    ) u_dut (
      .CLK     (clk),
      .RST_N   (rst_n),
      .start   (start_v[g]),
      .a       (a_v[g]),
      .b       (b_v[g]),
      .busy    (busy_v[g]),
      .done    (done_v[g]),
      .product (prod_v[g]),
      .CS      (cs_v[g]),
      .SCLK    (sclk_v[g]),
      .MOSI    (mosi_v[g]),
      .MISO    (miso)
    );

    // Peripheral: MOSI captured on SCLK rise, product bits launched on SCLK fall
    always @(posedge sclk_v[g], negedge sclk_v[g], posedge cs_v[g]) begin
      if (cs_v[g] === 1'b1) begin
        last_rises = rises;
        cs_rises   = cs_rises + 1;
        rises      = 0;
        miso       = 1'b0;
      end else if (sclk_v[g] === 1'b1) begin
        if (rises < 8) rx_byte = {rx_byte[6:0], mosi_v[g]};
        rises = rises + 1;
        if (rises == 8) begin
          ret  = {4'h0, rx_byte[7:4]} * {4'h0, rx_byte[3:0]};
          miso = ret[7];
        end
      end else if (rises >= 9 && rises <= 15) begin
        idx  = 3'(15 - rises);
        miso = ret[idx];
      end
    end

    // Counts done pulses seen on the clock
    always @(posedge clk) begin
      if (done_v[g] === 1'b1) dones <= dones + 1;
    end

    assign rx_v[g]    = rx_byte;
    assign lrise_v[g] = last_rises;
    assign csr_v[g]   = cs_rises;
    assign dcnt_v[g]  = dones;
  end

  typedef struct {
    logic       g;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] mosi;
    logic [7:0] prod;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic pulse_start(input logic g, input logic [3:0] av, input logic [3:0] bv);
    a_v[g]     = av;
    b_v[g]     = bv;
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  // Counts clock edges after the accepting edge until done is seen
  task automatic wait_done(input logic g, output int lat);
    lat = 0;
    while (done_v[g] !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_frame(input string name, input logic g, input logic [7:0] exp_mosi,
                             input logic [7:0] exp_prod, input int exp_lat, input int lat,
                             input logic [31:0] csr0);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_product"}, 32'(prod_v[g]), 32'(exp_prod));
    chk({name, "_mosi"}, 32'(rx_v[g]), 32'(exp_mosi));
    chk({name, "_sclk_rises"}, lrise_v[g], 32'd16);
    chk({name, "_cs_rises"}, csr_v[g] - csr0, 32'd1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          busy_low;
    logic [31:0] csr0;
    logic [31:0] d0;

    vecs[0] = '{1'b0, 4'd3,  4'd5,  8'h53, 8'h0F, 152};
    vecs[1] = '{1'b0, 4'd15, 4'd15, 8'hFF, 8'hE1, 152};
    vecs[2] = '{1'b0, 4'd0,  4'd9,  8'h90, 8'h00, 152};
    vecs[3] = '{1'b0, 4'd9,  4'd6,  8'h69, 8'h36, 152};
    vecs[4] = '{1'b1, 4'd4,  4'd4,  8'h44, 8'h10, 69};
    vecs[5] = '{1'b1, 4'd3,  4'd5,  8'h53, 8'h0F, 69};
    vecs[6] = '{1'b1, 4'd15, 4'd14, 8'hEF, 8'hD2, 69};

    rst_n   = 1'b1;
    start_v = '0;
    a_v     = '0;
    b_v     = '0;

    // Reset values, asynchronously before any clock edge
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_cs",      32'(cs_v[1'(i)]),   32'd1);
      chk("rst_sclk",    32'(sclk_v[1'(i)]), 32'd0);
      chk("rst_mosi",    32'(mosi_v[1'(i)]), 32'd0);
      chk("rst_busy",    32'(busy_v[1'(i)]), 32'd0);
      chk("rst_done",    32'(done_v[1'(i)]), 32'd0);
      chk("rst_product", 32'(prod_v[1'(i)]), 32'd0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single transactions on both timing builds
    for (int i = 0; i < 7; i++) begin
      csr0 = csr_v[vecs[i].g];
      pulse_start(vecs[i].g, vecs[i].a, vecs[i].b);
      chk("vec_busy", 32'(busy_v[vecs[i].g]), 32'd1);
      wait_done(vecs[i].g, lat);
      check_frame("vec", vecs[i].g, vecs[i].mosi, vecs[i].prod, vecs[i].lat, lat, csr0);
      @(negedge clk);
      chk("vec_done_width", 32'(done_v[vecs[i].g]), 32'd0);
      chk("vec_busy_after", 32'(busy_v[vecs[i].g]), 32'd0);
    end

    // start held three cycles, then re-pulsed mid-WRITE: one transaction only
    d0       = dcnt_v[0];
    csr0     = csr_v[0];
    busy_low = 0;
    a_v[0]     = 4'd1;
    b_v[0]     = 4'd2;
    start_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    start_v[0] = 1'b0;
    lat = 2;
    while (done_v[0] !== 1'b1 && lat < 1000) begin
      if (busy_v[0] !== 1'b1) busy_low++;
      if (lat == 30) begin
        a_v[0]     = 4'd7;
        b_v[0]     = 4'd7;
        start_v[0] = 1'b1;
      end
      if (lat == 31) start_v[0] = 1'b0;
      @(negedge clk);
      lat++;
    end
    check_frame("held_start", 1'b0, 8'h21, 8'h02, 152, lat, csr0);
    chk("held_busy_low_cycles", busy_low, 0);
    repeat (200) @(negedge clk);
    chk("held_done_count", dcnt_v[0] - d0, 32'd1);
    chk("held_busy_idle", 32'(busy_v[0]), 32'd0);

    // Reset during READ bit 4 aborts the frame
    d0 = dcnt_v[0];
    pulse_start(1'b0, 4'd3, 4'd4);
    lat = 0;
    while (lat < 110) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_busy_before", 32'(busy_v[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_cs",      32'(cs_v[0]),   32'd1);
    chk("abort_sclk",    32'(sclk_v[0]), 32'd0);
    chk("abort_product", 32'(prod_v[0]), 32'd0);
    chk("abort_busy",    32'(busy_v[0]), 32'd0);
    chk("abort_mosi",    32'(mosi_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("abort_no_done", dcnt_v[0] - d0, 32'd0);
    csr0 = csr_v[0];
    pulse_start(1'b0, 4'd6, 4'd7);
    wait_done(1'b0, lat);
    check_frame("after_abort", 1'b0, 8'h76, 8'h2A, 152, lat, csr0);
    @(negedge clk);

    // start in the done cycle is accepted immediately
    pulse_start(1'b0, 4'd5, 4'd5);
    wait_done(1'b0, lat);
    chk("chain_first_latency", lat, 152);
    chk("chain_first_product", 32'(prod_v[0]), 32'h19);
    csr0       = csr_v[0];
    a_v[0]     = 4'd2;
    b_v[0]     = 4'd7;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("chain_busy_no_gap", 32'(busy_v[0]), 32'd1);
    chk("chain_cs_low",      32'(cs_v[0]),   32'd0);
    wait_done(1'b0, lat);
    check_frame("chain_second", 1'b0, 8'h72, 8'h0E, 152, lat, csr0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
